amo_queue: RTL and testbench

Parametrised multi-entry successor to the single-slot AMO buffer in the load/store unit. It queues up to DEPTH atomic memory operations in program order and tracks per-entry commit state from the commit stage. It issues the oldest committed AMO to the cache subsystem once all stores have drained. A pipeline flush discards only speculative (uncommitted) entries; committed entries and an in-flight request survive.

---
 rtl/amo_queue.sv | 158 +++++++++++++++
 tb/tb_amo_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/amo_queue.sv
// amo_queue: in-order queue of atomic memory operations with commit tracking.
// Issues the oldest committed AMO to the cache once stores have drained.
package ariane_pkg;
  typedef enum logic [3:0] {
    AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP,
    AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
    AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU,
    AMO_CAS1, AMO_CAS2
  } amo_t;

  typedef struct packed {
    logic        req;
    amo_t        amo_op;
    logic [1:0]  size;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;
endpackage

module amo_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  amo_t                         amo_op_i,
  input  logic [ADDR_WIDTH-1:0]        paddr_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic [1:0]                   data_size_i,
  input  logic                         amo_commit_i,
  input  logic                         no_st_pending_i,
  output amo_req_t                     amo_req_o,
  input  amo_resp_t                    amo_resp_i,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t r_state, w_state_n;

  amo_t                  r_op    [DEPTH];
  logic [ADDR_WIDTH-1:0] r_paddr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data  [DEPTH];
  logic [1:0]            r_size  [DEPTH];
  logic                  r_cmtd  [DEPTH];

  logic [PW-1:0] r_rd, r_wr, r_cmt;
  logic [PW-1:0] w_rd_n, w_wr_n, w_cmt_n;
  logic [CW-1:0] r_cnt, r_ncmt;
  logic [CW-1:0] w_cnt_n, w_ncmt_n;

  logic w_push, w_commit, w_pop, w_req;
  logic w_unused;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_unused = ^amo_resp_i.result;

  assign ready_o  = (r_cnt < CW'(DEPTH));
  assign empty_o  = (r_cnt == '0);
  assign usage_o  = r_cnt;
  assign w_push   = valid_i & ready_o & ~flush_i;
  assign w_commit = amo_commit_i & (r_ncmt < r_cnt);
  assign w_pop    = w_req & amo_resp_i.ack;

  always_comb begin
    w_state_n = r_state;
    w_req     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_req = (r_ncmt != '0) & r_cmtd[r_rd]
              & no_st_pending_i;
        if (w_req & ~amo_resp_i.ack)
          w_state_n = S_REQ;
      end
      S_REQ: begin
        // held until ack; flush cannot touch a committed head
        w_req = 1'b1;
        if (amo_resp_i.ack)
          w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_n   = w_pop    ? f_inc(r_rd)  : r_rd;
    w_cmt_n  = w_commit ? f_inc(r_cmt) : r_cmt;
    w_ncmt_n = r_ncmt + CW'(w_commit) - CW'(w_pop);
    w_wr_n   = w_push   ? f_inc(r_wr)  : r_wr;
    w_cnt_n  = r_cnt + CW'(w_push) - CW'(w_pop);
    if (flush_i) begin
      w_wr_n  = w_cmt_n;
      w_cnt_n = w_ncmt_n;
    end
  end

  always_comb begin
    amo_req_o           = '0;
    amo_req_o.req       = w_req;
    amo_req_o.amo_op    = r_op[r_rd];
    amo_req_o.size      = r_size[r_rd];
    amo_req_o.operand_a = 64'(r_paddr[r_rd]);
    amo_req_o.operand_b = 64'(r_data[r_rd]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_rd    <= '0;
      r_wr    <= '0;
      r_cmt   <= '0;
      r_cnt   <= '0;
      r_ncmt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]    <= AMO_NONE;
        r_paddr[i] <= '0;
        r_data[i]  <= '0;
        r_size[i]  <= '0;
        r_cmtd[i]  <= 1'b0;
      end
    end else begin
      r_state <= w_state_n;
      r_rd    <= w_rd_n;
      r_wr    <= w_wr_n;
      r_cmt   <= w_cmt_n;
      r_cnt   <= w_cnt_n;
      r_ncmt  <= w_ncmt_n;
      if (w_push) begin
        r_op[r_wr]    <= amo_op_i;
        r_paddr[r_wr] <= paddr_i;
        r_data[r_wr]  <= data_i;
        r_size[r_wr]  <= data_size_i;
        r_cmtd[r_wr]  <= 1'b0;
      end
      if (w_commit)
        r_cmtd[r_cmt] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_amo_queue.sv
// tb_amo_queue: directed and random stimulus against a queue-based
// reference model of the AMO queue (DEPTH=3, ADDR_WIDTH=56).
module tb_amo_queue;
  import ariane_pkg::*;

  localparam int DEPTH = 3;
  localparam int AW    = 56;
  localparam int DW    = 64;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          flush, valid, commit, nost;
  amo_t          op;
  logic [AW-1:0] paddr;
  logic [DW-1:0] data;
  logic [1:0]    sz;
  logic          ready, empty;
  logic [1:0]    usage;
  amo_req_t      req;
  amo_resp_t     resp;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    amo_t        op;
    logic [63:0] a;
    logic [63:0] d;
    logic [1:0]  sz;
  } ent_t;

  ent_t q[$];
  int   m_ncmt;
  bit   m_held;

  always #5 clk = ~clk;

  amo_queue #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .valid_i(valid), .ready_o(ready),
    .amo_op_i(op), .paddr_i(paddr), .data_i(data),
    .data_size_i(sz), .amo_commit_i(commit),
    .no_st_pending_i(nost), .amo_req_o(req),
    .amo_resp_i(resp), .empty_o(empty),
    .usage_o(usage)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ncmt = 0;
    m_held = 0;
  endtask

  task automatic step(input bit v, input bit c,
                      input bit ns, input bit ak,
                      input bit fl);
    bit m_req, push, cmt, pop;
    ent_t e;
    @(negedge clk);
    valid = v; commit = c; nost = ns;
    resp.ack = ak; flush = fl;
    op    = amo_t'($urandom_range(0, 13));
    paddr = AW'({$urandom, $urandom});
    data  = {$urandom, $urandom};
    sz    = 2'($urandom);
    #1;
    m_req = m_held || (m_ncmt > 0 && ns);
    chk("ready", 64'(ready), 64'(q.size() < DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("usage", 64'(usage), 64'(q.size()));
    chk("req",   64'(req.req), 64'(m_req));
    if (q.size() > 0) begin
      chk("op",   64'(req.amo_op), 64'(q[0].op));
      chk("size", 64'(req.size), 64'(q[0].sz));
      chk("opa",  req.operand_a, q[0].a);
      chk("opb",  req.operand_b, q[0].d);
    end
    push = v && q.size() < DEPTH && !fl;
    cmt  = c && m_ncmt < q.size();
    pop  = m_req && ak;
    if (cmt) m_ncmt++;
    if (pop) begin
      q.delete(0);
      m_ncmt--;
    end
    if (push) begin
      e.op = op; e.a = 64'(paddr);
      e.d = data; e.sz = sz;
      q.push_back(e);
    end
    if (fl)
      while (q.size() > m_ncmt) q.delete(q.size() - 1);
    if (!m_held && m_req && !ak) m_held = 1;
    else if (m_held && ak) m_held = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0);
  endtask

  initial begin
    flush = 0; valid = 0; commit = 0; nost = 0;
    op = AMO_NONE; paddr = '0; data = '0; sz = '0;
    resp = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;

    // reset then idle
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);

    // fill, overflow drop, commit, issue, flush the rest
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("full_ready", 64'(ready), 64'(0));
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 0);
    idle(3);

    // commit and flush in the same cycle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 0);
    idle(2);

    // store drain gating and held request
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    idle(2);

    // pointer wrap rounds with upper address bits
    for (int r = 0; r < 7; r++) begin
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("opa_hi", 64'(req.operand_a[63:56]), 64'(0));
      step(0, 0, 1, 1, 0);
    end

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 5);

    // async reset while a request is held
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    @(negedge clk);
    resp.ack = 0; valid = 0; commit = 0; flush = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_req",   64'(req.req), 64'(0));
    chk("rst_usage", 64'(usage), 64'(0));
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
